siusn_decode: RTL and testbench

Recovers the 8-bit SRU DCS IP octet from a 32-bit DDL SIU serial number held as four ASCII decimal characters (most significant digit in bits [31:24]). It is the inverse of the serial-number generation path and sits on the readback side of the DDL link. The block checks each character, accumulates the decimal value one digit per clock, and reports it with character and range error flags. A start/busy/done handshake gates each conversion.

---
 rtl/siusn_decode.sv | 150 +++++++++++++++
 tb/tb_siusn_decode.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/siusn_decode.sv
// siusn_decode: converts a four-character ASCII decimal SIU serial number
// back into the SRU DCS IP octet. One digit is accumulated per clock, and
// character and range errors are reported alongside the result.
module siusn_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] siusn_in,
  output logic        busy,
  output logic        done,
  output logic [13:0] value,
  output logic [7:0]  sruip,
  output logic        char_err,
  output logic        range_err
);

  localparam int unsigned SN_W    = 32;
  localparam int unsigned CH_W    = 8;
  localparam int unsigned ACC_W   = 14;
  localparam int unsigned DIG_W   = 4;
  localparam int unsigned CNT_W   = 2;
  localparam int unsigned IP_W    = 8;
  localparam int unsigned IP_MAX  = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q,     state_d;
  logic [SN_W-1:0]     shreg_q,     shreg_d;
  logic [ACC_W-1:0]    acc_q,       acc_d;
  logic [CNT_W-1:0]    cnt_q,       cnt_d;
  logic                cerr_q,      cerr_d;
  logic                busy_q,      busy_d;
  logic                done_q,      done_d;
  logic [ACC_W-1:0]    value_q,     value_d;
  logic [IP_W-1:0]     sruip_q,     sruip_d;
  logic                char_err_q,  char_err_d;
  logic                range_err_q, range_err_d;

  // Current character and its decimal digit (invalid characters count as 0).
  logic [CH_W-1:0]     ch_c;
  logic                ch_ok_c;
  logic [DIG_W-1:0]    digit_c;
  logic [ACC_W-1:0]    acc_next_c;
  logic                over_c;

  // Decode the top character of the shift register and form acc*10 + digit.
  always_comb begin
    ch_c       = shreg_q[SN_W-1 -: CH_W];
    ch_ok_c    = (ch_c >= 8'h30) && (ch_c <= 8'h39);
    digit_c    = ch_ok_c ? DIG_W'(ch_c - 8'h30) : '0;
    acc_next_c = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit_c);
    over_c     = (acc_q > ACC_W'(IP_MAX));
  end

  // Next-state and datapath/output logic for the conversion sequencer.
  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    cerr_d      = cerr_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    value_d     = value_q;
    sruip_d     = sruip_q;
    char_err_d  = char_err_q;
    range_err_d = range_err_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = siusn_in;
          acc_d   = '0;
          cerr_d  = 1'b0;
          cnt_d   = CNT_W'(3);
          busy_d  = 1'b1;
          state_d = CONV;
        end
      end

      CONV: begin
        shreg_d = shreg_q << CH_W;
        acc_d   = acc_next_c;
        if (!ch_ok_c) begin
          cerr_d = 1'b1;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end

      DONE: begin
        value_d     = acc_q;
        char_err_d  = cerr_q;
        range_err_d = over_c;
        sruip_d     = (cerr_q || over_c) ? '0 : acc_q[IP_W-1:0];
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      cerr_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      value_q     <= '0;
      sruip_q     <= '0;
      char_err_q  <= 1'b0;
      range_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      cerr_q      <= cerr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      value_q     <= value_d;
      sruip_q     <= sruip_d;
      char_err_q  <= char_err_d;
      range_err_q <= range_err_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign value     = value_q;
  assign sruip     = sruip_q;
  assign char_err  = char_err_q;
  assign range_err = range_err_q;

endmodule

// File: tb/tb_siusn_decode.sv
// Directed testbench for siusn_decode: known serial numbers, full 0..255
// round trip, handshake behaviour and reset abort.
module tb_siusn_decode;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] siusn_in;
  logic        busy;
  logic        done;
  logic [13:0] value;
  logic [7:0]  sruip;
  logic        char_err;
  logic        range_err;

  int checks;
  int errors;
  int done_cnt;
  int double_done;
  logic prev_done;

  siusn_decode dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .siusn_in  (siusn_in),
    .busy      (busy),
    .done      (done),
    .value     (value),
    .sruip     (sruip),
    .char_err  (char_err),
    .range_err (range_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [13:0] e_val, input logic [7:0] e_ip,
                         input logic e_ce, input logic e_re);
    chk({tag, "_value"}, 32'(value), 32'(e_val));
    chk({tag, "_sruip"}, 32'(sruip), 32'(e_ip));
    chk({tag, "_errs"}, 32'({char_err, range_err}), 32'({e_ce, e_re}));
  endtask

  // Start pulse, then check busy and that done appears exactly 5 edges later.
  task automatic conv(input logic [31:0] sn, input string tag);
    @(negedge clk);
    siusn_in = sn;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      chk({tag, "_done_t"}, 32'(done), (i == 5) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    start       = 1'b0;
    siusn_in    = 32'h0;
    prev_done   = 1'b0;
    done_cnt    = 0;
    double_done = 0;

    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk_res("rst", 14'd0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;

    // Idle without start stays idle.
    repeat (3) @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Directed vectors.
    conv(32'h30313037, "v0107");
    chk_res("v0107", 14'd107, 8'h6B, 1'b0, 1'b0);
    chk("v0107_busy_low", 32'(busy), 32'd0);
    @(negedge clk);
    chk("v0107_done_fall", 32'(done), 32'd0);
    chk_res("v0107_hold", 14'd107, 8'h6B, 1'b0, 1'b0);

    conv(32'h30323535, "v0255");
    chk_res("v0255", 14'd255, 8'hFF, 1'b0, 1'b0);
    conv(32'h30323536, "v0256");
    chk_res("v0256", 14'd256, 8'h00, 1'b0, 1'b1);
    conv(32'h39393939, "v9999");
    chk_res("v9999", 14'd9999, 8'h00, 1'b0, 1'b1);
    conv(32'h30413132, "v0A12");
    chk_res("v0A12", 14'd12, 8'h00, 1'b1, 1'b0);
    conv(32'h30303030, "v0000");
    chk_res("v0000", 14'd0, 8'h00, 1'b0, 1'b0);
    conv(32'h2F3A3030, "vbad");
    chk_res("vbad", 14'd0, 8'h00, 1'b1, 1'b0);

    // Round trip over every IP octet.
    for (int ip = 0; ip < 256; ip++) begin
      logic [31:0] sn;
      sn = {8'h30, 8'(8'h30 + ip / 100), 8'(8'h30 + (ip / 10) % 10), 8'(8'h30 + ip % 10)};
      conv(sn, "rt");
      chk("rt_result", 32'({value, sruip, char_err, range_err}),
          32'({14'(ip), 8'(ip), 2'b00}));
    end

    // Start held high for 10 cycles: accepted twice.
    @(negedge clk);
    siusn_in = 32'h30313037;
    start    = 1'b1;
    done_cnt = 0;
    prev_done = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (i == 9) start = 1'b0;
      if (done) done_cnt++;
      if (done && prev_done) double_done++;
      prev_done = done;
    end
    chk("hold_done_count", 32'(done_cnt), 32'd2);
    chk("hold_done_width", 32'(double_done), 32'd0);
    chk_res("hold", 14'd107, 8'h6B, 1'b0, 1'b0);

    // Input change after the start sample does not disturb the conversion.
    @(negedge clk);
    siusn_in = 32'h30313939;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    siusn_in = 32'h39393939;
    done_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("latch_done_count", 32'(done_cnt), 32'd1);
    chk_res("latch", 14'd199, 8'hC7, 1'b0, 1'b0);

    // Reset in the middle of a conversion.
    @(negedge clk);
    siusn_in = 32'h30303530;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk_res("abort", 14'd0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'd0);
    chk("abort_idle_busy", 32'(busy), 32'd0);

    conv(32'h30303530, "post_rst");
    chk_res("post_rst", 14'd50, 8'h32, 1'b0, 1'b0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
